// File: rtl/game_pkg.sv
// Court geometry, score limits and the game FSM encoding shared by the shot
// sequencer, the kinematic datapath and the VGA renderer.
package game_pkg;

   localparam logic [9:0] HD          = 10'd640;
   localparam logic [9:0] VD          = 10'd480;
   localparam logic [9:0] BALL_RADIUS = 10'd4;
   localparam logic [9:0] HOOP_X_L    = 10'd610;
   localparam logic [9:0] HOOP_X_R    = 10'd630;
   localparam logic [9:0] HOOP_Y_T    = 10'd155;
   localparam logic [9:0] HOOP_Y_B    = 10'd159;
   localparam logic [9:0] BOARD_X_L   = 10'd631;
   localparam logic [9:0] BOARD_X_R   = 10'd635;
   localparam logic [9:0] BOARD_Y_T   = 10'd110;
   localparam logic [9:0] BOARD_Y_B   = 10'd159;

   // Ball centre limits at which it has hit the floor or the right edge.
   localparam logic [9:0] FLOOR_Y = VD - 10'd1 - BALL_RADIUS;
   localparam logic [9:0] WALL_X  = HD - 10'd1;

   localparam logic [6:0] SCORE_MAX = 7'd99;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_AIM    = 2'd1,
      ST_FLIGHT = 2'd2,
      ST_RESULT = 2'd3
   } game_state_t;

   function automatic logic [6:0] sat_inc(input logic [6:0] v);
      return (v >= SCORE_MAX) ? SCORE_MAX : v + 7'd1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a registered one-cycle strobe every
// CLK_HZ/TICK_HZ clocks; the strobe is high on the cycle the counter wraps.
module tick_gen #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/shot_controller.sv
// Game-flow sequencer: aim -> flight -> result, drives kinematic's released
// and reset inputs, judges make/miss on physics ticks and keeps the tallies.
module shot_controller
   import game_pkg::*;
#(
   parameter int CLK_HZ           = 100_000_000,
   parameter int TICK_HZ          = 100,
   parameter int AIM_MIN_TICKS    = 20,
   parameter int FLIGHT_MAX_TICKS = 500,
   parameter int RESULT_TICKS     = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       shoot,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   output logic       tick,
   output logic       released,
   output logic       phys_rst,
   output logic       made,
   output logic       missed,
   output logic [6:0] score,
   output logic [6:0] shots,
   output logic [1:0] state
);

   localparam int TW = 16;
   localparam logic [TW-1:0] AIM_MIN     = TW'(AIM_MIN_TICKS);
   localparam logic [TW-1:0] FLIGHT_LAST = TW'(FLIGHT_MAX_TICKS - 1);
   localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_TICKS - 1);

   game_state_t   state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [9:0]    prev_y_q, prev_y_d;
   logic          released_q, released_d;
   logic          phys_rst_q, phys_rst_d;
   logic          made_q, made_d;
   logic          missed_q, missed_d;
   logic [6:0]    score_q, score_d;
   logic [6:0]    shots_q, shots_d;
   logic          hit, out_of_play;

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // A make is a downward crossing of the rim line inside the hoop span.
   assign hit = (prev_y_q < HOOP_Y_T) && (ball_y >= HOOP_Y_T) &&
                (ball_x >= HOOP_X_L) && (ball_x <= HOOP_X_R);
   assign out_of_play = (ball_y >= FLOOR_Y) || (ball_x >= WALL_X) ||
                        (tcnt_q == FLIGHT_LAST);

   // shoot is a single-cycle pulse with no back-pressure: it is acted on
   // only in IDLE and in AIM once the minimum aim time has elapsed.
   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      prev_y_d   = prev_y_q;
      released_d = released_q;
      phys_rst_d = 1'b0;
      made_d     = 1'b0;
      missed_d   = 1'b0;
      score_d    = score_q;
      shots_d    = shots_q;
      case (state_q)
         ST_IDLE: begin
            tcnt_d     = '0;
            released_d = 1'b0;
            if (shoot) state_d = ST_AIM;
         end
         ST_AIM: begin
            released_d = 1'b0;
            if (shoot && (tcnt_q >= AIM_MIN)) begin
               state_d    = ST_FLIGHT;
               released_d = 1'b1;
               shots_d    = sat_inc(shots_q);
               tcnt_d     = '0;
               prev_y_d   = ball_y;
            end else if (tick && (tcnt_q < AIM_MIN)) begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_FLIGHT: begin
            released_d = 1'b1;
            if (tick) begin
               if (hit) begin
                  made_d  = 1'b1;
                  score_d = sat_inc(score_q);
                  state_d = ST_RESULT;
                  tcnt_d  = '0;
               end else if (out_of_play) begin
                  missed_d = 1'b1;
                  state_d  = ST_RESULT;
                  tcnt_d   = '0;
               end else begin
                  prev_y_d = ball_y;
                  tcnt_d   = tcnt_q + TW'(1);
               end
            end
         end
         ST_RESULT: begin
            if (tick) begin
               if (tcnt_q == RESULT_LAST) begin
                  state_d    = ST_IDLE;
                  phys_rst_d = 1'b1;
                  released_d = 1'b0;
                  tcnt_d     = '0;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tcnt_q     <= '0;
         prev_y_q   <= '0;
         released_q <= 1'b0;
         phys_rst_q <= 1'b0;
         made_q     <= 1'b0;
         missed_q   <= 1'b0;
         score_q    <= '0;
         shots_q    <= '0;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         prev_y_q   <= prev_y_d;
         released_q <= released_d;
         phys_rst_q <= phys_rst_d;
         made_q     <= made_d;
         missed_q   <= missed_d;
         score_q    <= score_d;
         shots_q    <= shots_d;
      end
   end

   assign released = released_q;
   assign phys_rst = phys_rst_q;
   assign made     = made_q;
   assign missed   = missed_q;
   assign score    = score_q;
   assign shots    = shots_q;
   assign state    = state_q;

endmodule

// File: tb/tb_shot_controller.sv
// Self-checking bench for shot_controller with a fast tick (every 10 cycles)
// and short aim/flight/result windows; make/miss events go through a queue.
module tb_shot_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       shoot = 1'b0;
   logic [9:0] ball_x = '0;
   logic [9:0] ball_y = '0;
   logic       tick, released, phys_rst, made, missed;
   logic [6:0] score, shots;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];
   logic [6:0] sc_exp = '0;
   logic [6:0] sh_exp = '0;

   always #5 clk = ~clk;

   shot_controller #(
      .CLK_HZ           (1000),
      .TICK_HZ          (100),
      .AIM_MIN_TICKS    (2),
      .FLIGHT_MAX_TICKS (20),
      .RESULT_TICKS     (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .shoot    (shoot),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .tick     (tick),
      .released (released),
      .phys_rst (phys_rst),
      .made     (made),
      .missed   (missed),
      .score    (score),
      .shots    (shots),
      .state    (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] sat(input logic [6:0] v);
      return (v >= 7'd99) ? 7'd99 : v + 7'd1;
   endfunction

   // Every make/miss pulse must match the next queued event {made,missed,score}.
   always @(negedge clk) begin
      if (made === 1'b1 || missed === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("evt_unexpected", {30'd0, made, missed}, 32'd0);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("evt", {23'd0, made, missed, score}, {23'd0, e});
         end
      end
   end

   // Returns at the negedge of the next cycle with tick high.
   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (tick) seen = 1'b1;
      end
      if (!seen) check("tick_wait", {31'd0, tick}, 32'd1);
   endtask

   // Returns at the negedge right after the tick has been consumed.
   task automatic step_tick();
      wait_tick();
      @(negedge clk);
   endtask

   task automatic pulse_shoot();
      shoot = 1'b1;
      @(negedge clk);
      shoot = 1'b0;
   endtask

   task automatic start_flight(input logic [9:0] y, input logic [9:0] x);
      ball_y = y;
      ball_x = x;
      pulse_shoot();
      step_tick();
      step_tick();
      pulse_shoot();
      sh_exp = sat(sh_exp);
      check("launch_state", {30'd0, state}, 32'd2);
      check("launch_released", {31'd0, released}, 32'd1);
      check("launch_shots", {25'd0, shots}, {25'd0, sh_exp});
   endtask

   task automatic finish_result();
      repeat (2) step_tick();
      check("result_hold", {30'd0, state}, 32'd3);
      step_tick();
      check("phys_rst_on", {31'd0, phys_rst}, 32'd1);
      check("back_idle", {30'd0, state}, 32'd0);
      check("released_off", {31'd0, released}, 32'd0);
      @(negedge clk);
      check("phys_rst_off", {31'd0, phys_rst}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values, then free-running tick while idle.
      repeat (3) @(negedge clk);
      check("rst_tick", {31'd0, tick}, 32'd0);
      check("rst_outs", {17'd0, released, phys_rst, made, missed, score, shots}, 32'd0);
      check("rst_state", {30'd0, state}, 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         check("idle_tick", {31'd0, tick}, {31'd0, (k % 10 == 0)});
         check("idle_outs", {15'd0, released, phys_rst, made, missed, score, shots, state}, 32'd0);
      end

      // Early press in AIM is ignored; press after the second tick launches.
      ball_y = 10'd150;
      ball_x = 10'd620;
      pulse_shoot();
      check("aim_enter", {30'd0, state}, 32'd1);
      step_tick();
      pulse_shoot();
      check("aim_early_state", {30'd0, state}, 32'd1);
      check("aim_early_rel", {31'd0, released}, 32'd0);
      check("aim_early_shots", {25'd0, shots}, 32'd0);
      step_tick();
      pulse_shoot();
      sh_exp = sat(sh_exp);
      check("aim_go_rel", {31'd0, released}, 32'd1);
      check("aim_go_shots", {25'd0, shots}, {25'd0, sh_exp});

      // Rim crossing inside the hoop span scores.
      ball_y = 10'd157;
      sc_exp = sat(sc_exp);
      exp_q.push_back({1'b1, 1'b0, sc_exp});
      step_tick();
      check("make_state", {30'd0, state}, 32'd3);
      check("make_score", {25'd0, score}, {25'd0, sc_exp});
      pulse_shoot();
      check("result_shoot_ign", {25'd0, shots}, {25'd0, sh_exp});
      check("made_one_cycle", {31'd0, made}, 32'd0);
      finish_result();

      // Ball hangs mid-court until the flight timeout.
      start_flight(10'd200, 10'd100);
      exp_q.push_back({1'b0, 1'b1, sc_exp});
      repeat (19) step_tick();
      check("timeout_pre", {30'd0, state}, 32'd2);
      step_tick();
      check("timeout_state", {30'd0, state}, 32'd3);
      check("timeout_score", {25'd0, score}, {25'd0, sc_exp});
      finish_result();

      // Make and timeout on the same tick: make wins.
      start_flight(10'd100, 10'd625);
      repeat (19) step_tick();
      ball_y = 10'd160;
      sc_exp = sat(sc_exp);
      exp_q.push_back({1'b1, 1'b0, sc_exp});
      step_tick();
      check("both_state", {30'd0, state}, 32'd3);
      finish_result();

      // Press coinciding with a tick uses the pre-increment aim count.
      ball_y = 10'd475;
      ball_x = 10'd100;
      pulse_shoot();
      step_tick();
      wait_tick();
      pulse_shoot();
      check("coinc_state", {30'd0, state}, 32'd1);
      check("coinc_shots", {25'd0, shots}, {25'd0, sh_exp});
      pulse_shoot();
      sh_exp = sat(sh_exp);
      check("coinc_launch", {30'd0, state}, 32'd2);
      exp_q.push_back({1'b0, 1'b1, sc_exp});
      step_tick();
      check("floor_state", {30'd0, state}, 32'd3);
      finish_result();

      // Asynchronous reset in mid-flight.
      start_flight(10'd300, 10'd100);
      step_tick();
      rst = 1'b1;
      #1;
      check("arst_released", {31'd0, released}, 32'd0);
      check("arst_counts", {18'd0, score, shots}, 32'd0);
      check("arst_state", {30'd0, state}, 32'd0);
      sc_exp = '0;
      sh_exp = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("arst_resume", {30'd0, state}, 32'd0);

      // Saturation of both tallies.
      for (int i = 0; i < 105; i++) begin
         start_flight(10'd150, 10'd620);
         ball_y = 10'd157;
         sc_exp = sat(sc_exp);
         exp_q.push_back({1'b1, 1'b0, sc_exp});
         step_tick();
         finish_result();
      end
      check("sat_score", {25'd0, score}, 32'd99);
      check("sat_shots", {25'd0, shots}, 32'd99);
      check("q_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
